// File: rtl/sim_watchdog.sv
// Bench watchdog: synchronised reset release, core reset hold,
// retire-heartbeat hang detection and sticky error with cause code.
module sim_watchdog #(
  parameter int RST_CYCLES   = 2,
  parameter int BOOT_TIMEOUT = 16,
  parameter int RUN_TIMEOUT  = 8,
  parameter int HB_W         = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            heartbeat,
  input  logic            halt,
  input  logic            fault_in,
  input  logic            clr,
  output logic            core_rst,
  output logic            err,
  output logic [1:0]      err_cause,
  output logic [2:0]      state,
  output logic [HB_W-1:0] hb_count
);

  localparam int MAXT = (BOOT_TIMEOUT > RUN_TIMEOUT) ?
                        BOOT_TIMEOUT : RUN_TIMEOUT;
  localparam int CW   = $clog2(MAXT + 1);

  localparam logic [CW-1:0]   RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0]   BOOT_LAST = CW'(BOOT_TIMEOUT - 1);
  localparam logic [CW-1:0]   RUN_LAST  = CW'(RUN_TIMEOUT - 1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [HB_W-1:0] HB_ONE    = HB_W'(1);

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_BOOT   = 3'd1,
    S_RUN    = 3'd2,
    S_HALTED = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  logic            r_sync1;
  logic            r_sync2;
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [HB_W-1:0] r_hb;
  logic            r_core_rst;
  logic            r_err;
  logic [1:0]      r_cause;

  state_t          w_state_nx;
  logic [CW-1:0]   w_cnt_nx;
  logic [HB_W-1:0] w_hb_nx;
  logic            w_core_rst_nx;
  logic            w_err_nx;
  logic [1:0]      w_cause_nx;
  logic [HB_W-1:0] w_hb_inc;
  logic [CW-1:0]   w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= 1'b1;
      r_sync2 <= r_sync1;
    end
  end

  assign w_hb_inc = (r_hb == '1) ? r_hb : r_hb + HB_ONE;
  assign w_last   = (r_state == S_BOOT) ? BOOT_LAST : RUN_LAST;

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_hb_nx       = r_hb;
    w_core_rst_nx = r_core_rst;
    w_err_nx      = r_err;
    w_cause_nx    = r_cause;
    unique case (r_state)
      S_HOLD: begin
        if (clr) begin
          w_cnt_nx = '0;
        end else if (r_sync2) begin
          if (r_cnt == RST_LAST) begin
            w_state_nx    = S_BOOT;
            w_core_rst_nx = 1'b0;
            w_cnt_nx      = '0;
          end else begin
            w_cnt_nx = r_cnt + CNT_ONE;
          end
        end
      end
      S_BOOT, S_RUN: begin
        if (clr) begin
          w_state_nx    = S_HOLD;
          w_core_rst_nx = 1'b1;
          w_err_nx      = 1'b0;
          w_cause_nx    = 2'b00;
          w_cnt_nx      = '0;
          w_hb_nx       = '0;
        end else if (fault_in) begin
          w_state_nx = S_FAULT;
          w_err_nx   = 1'b1;
          w_cause_nx = 2'b11;
        end else if (halt) begin
          w_state_nx = S_HALTED;
        end else if (heartbeat) begin
          w_state_nx = S_RUN;
          w_cnt_nx   = '0;
          w_hb_nx    = w_hb_inc;
        end else if (r_cnt == w_last) begin
          w_state_nx = S_FAULT;
          w_err_nx   = 1'b1;
          w_cause_nx = (r_state == S_BOOT) ? 2'b01 : 2'b10;
        end else begin
          w_cnt_nx = r_cnt + CNT_ONE;
        end
      end
      S_HALTED, S_FAULT: begin
        if (clr) begin
          w_state_nx    = S_HOLD;
          w_core_rst_nx = 1'b1;
          w_err_nx      = 1'b0;
          w_cause_nx    = 2'b00;
          w_cnt_nx      = '0;
          w_hb_nx       = '0;
        end
      end
      default: begin
        w_state_nx    = S_HOLD;
        w_core_rst_nx = 1'b1;
        w_err_nx      = 1'b0;
        w_cause_nx    = 2'b00;
        w_cnt_nx      = '0;
        w_hb_nx       = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_HOLD;
      r_cnt      <= '0;
      r_hb       <= '0;
      r_core_rst <= 1'b1;
      r_err      <= 1'b0;
      r_cause    <= 2'b00;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_hb       <= w_hb_nx;
      r_core_rst <= w_core_rst_nx;
      r_err      <= w_err_nx;
      r_cause    <= w_cause_nx;
    end
  end

  assign core_rst  = r_core_rst;
  assign err       = r_err;
  assign err_cause = r_cause;
  assign state     = r_state;
  assign hb_count  = r_hb;

endmodule

// File: tb/tb_sim_watchdog.sv
// Randomised and directed bench for sim_watchdog against
// an event-level reference model.
module tb_sim_watchdog;

  localparam int RST_CYCLES = 2;
  localparam int BOOT_TO    = 16;
  localparam int RUN_TO     = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        heartbeat = 1'b0;
  logic        halt = 1'b0;
  logic        fault_in = 1'b0;
  logic        clr = 1'b0;
  logic        core_rst, err;
  logic [1:0]  err_cause;
  logic [2:0]  state;
  logic [15:0] hb_count;
  logic        core_rst4, err4;
  logic [1:0]  cause4;
  logic [2:0]  state4;
  logic [3:0]  hb4;

  int n_checks = 0;
  int n_errors = 0;

  int m_st, m_cause, m_hold, m_sil, m_hb, m_sync;

  always #5 clk = ~clk;

  sim_watchdog #(
    .RST_CYCLES(RST_CYCLES), .BOOT_TIMEOUT(BOOT_TO),
    .RUN_TIMEOUT(RUN_TO), .HB_W(16)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .heartbeat(heartbeat),
    .halt(halt), .fault_in(fault_in), .clr(clr),
    .core_rst(core_rst), .err(err), .err_cause(err_cause),
    .state(state), .hb_count(hb_count)
  );

  sim_watchdog #(
    .RST_CYCLES(RST_CYCLES), .BOOT_TIMEOUT(BOOT_TO),
    .RUN_TIMEOUT(RUN_TO), .HB_W(4)
  ) u_dut4 (
    .clk(clk), .rst_n(rst_n), .heartbeat(heartbeat),
    .halt(halt), .fault_in(fault_in), .clr(clr),
    .core_rst(core_rst4), .err(err4), .err_cause(cause4),
    .state(state4), .hb_count(hb4)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void m_clear();
    m_st    = 0;
    m_cause = 0;
    m_hold  = 0;
    m_sil   = 0;
    m_hb    = 0;
  endfunction

  function automatic void m_reset();
    m_clear();
    m_sync = 0;
  endfunction

  // One rising edge of the reference behaviour.
  function automatic void m_step();
    bit sync_ok;
    if (!rst_n) begin
      m_reset();
      return;
    end
    sync_ok = (m_sync >= 2);
    if (m_sync < 2) m_sync++;
    if (clr && m_st != 0) begin
      m_clear();
    end else if (m_st == 0) begin
      if (clr) m_hold = 0;
      else if (sync_ok) begin
        m_hold++;
        if (m_hold == RST_CYCLES) begin
          m_st  = 1;
          m_sil = 0;
        end
      end
    end else if (m_st == 1 || m_st == 2) begin
      if (fault_in) begin
        m_st    = 4;
        m_cause = 3;
      end else if (halt) begin
        m_st = 3;
      end else if (heartbeat) begin
        m_st  = 2;
        m_sil = 0;
        m_hb++;
      end else begin
        m_sil++;
        if (m_st == 1 && m_sil == BOOT_TO) begin
          m_st    = 4;
          m_cause = 1;
        end else if (m_st == 2 && m_sil == RUN_TO) begin
          m_st    = 4;
          m_cause = 2;
        end
      end
    end
  endfunction

  task automatic check_all();
    int e16, e4;
    e16 = (m_hb > 65535) ? 65535 : m_hb;
    e4  = (m_hb > 15) ? 15 : m_hb;
    chk("state", 32'(state), m_st);
    chk("core_rst", 32'(core_rst), 32'(m_st == 0));
    chk("err", 32'(err), 32'(m_st == 4));
    chk("err_cause", 32'(err_cause), m_cause);
    chk("hb_count", 32'(hb_count), e16);
    chk("state4", 32'(state4), m_st);
    chk("core_rst4", 32'(core_rst4), 32'(m_st == 0));
    chk("err4", 32'(err4), 32'(m_st == 4));
    chk("cause4", 32'(cause4), m_cause);
    chk("hb4", 32'(hb4), e4);
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic async_rst(input string tag, input int low_cycles);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_core_rst"}, 32'(core_rst), 1);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_cause"}, 32'(err_cause), 0);
    chk({tag, "_hb"}, 32'(hb_count), 0);
    m_reset();
    repeat (low_cycles) tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    int edges;
    int pulses;
    int hb_pct;
    m_reset();

    // 1: release and core reset hold
    repeat (3) tick();
    rst_n = 1'b1;
    edges = 0;
    while (core_rst && edges < 20) begin
      tick();
      edges++;
    end
    chk("t1_rel_edges", edges, 4);
    chk("t1_state", 32'(state), 1);

    // 2: boot hang
    edges = 0;
    while (!err && edges < 40) begin
      tick();
      edges++;
    end
    chk("t2_boot_edges", edges, BOOT_TO);
    chk("t2_cause", 32'(err_cause), 1);
    chk("t2_state", 32'(state), 4);
    repeat (20) tick();
    chk("t2_sticky", 32'(err), 1);

    // 3: periodic heartbeats then run hang
    pulse_clr();
    chk("t3_hold", 32'(state), 0);
    repeat (2) tick();
    chk("t3_boot", 32'(state), 1);
    pulses = 0;
    for (int c = 0; c < 50; c++) begin
      heartbeat = (c % 7 == 0);
      if (heartbeat) pulses++;
      tick();
    end
    heartbeat = 1'b0;
    edges = 0;
    while (!err && edges < 30) begin
      tick();
      edges++;
    end
    chk("t3_run_edges", edges, RUN_TO);
    chk("t3_cause", 32'(err_cause), 2);
    chk("t3_hb_count", 32'(hb_count), pulses);

    // 4: fault with halt, then clear
    pulse_clr();
    repeat (2) tick();
    heartbeat = 1'b1;
    tick();
    heartbeat = 1'b0;
    chk("t4_run", 32'(state), 2);
    fault_in = 1'b1;
    halt = 1'b1;
    tick();
    fault_in = 1'b0;
    halt = 1'b0;
    chk("t4_err", 32'(err), 1);
    chk("t4_cause", 32'(err_cause), 3);
    pulse_clr();
    chk("t4_clr_rst", 32'(core_rst), 1);
    chk("t4_clr_err", 32'(err), 0);
    chk("t4_clr_state", 32'(state), 0);
    repeat (2) tick();
    chk("t4_reboot", 32'(state), 1);

    // 5: halted ignores everything
    heartbeat = 1'b1;
    tick();
    heartbeat = 1'b0;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("t5_halted", 32'(state), 3);
    for (int c = 0; c < 100; c++) begin
      fault_in = 1'($urandom_range(0, 1));
      halt = 1'($urandom_range(0, 1));
      tick();
    end
    fault_in = 1'b0;
    halt = 1'b0;
    chk("t5_no_err", 32'(err), 0);

    // 6: heartbeat on the timeout edge, async reset mid-run
    pulse_clr();
    repeat (2) tick();
    heartbeat = 1'b1;
    tick();
    heartbeat = 1'b0;
    repeat (RUN_TO - 1) tick();
    heartbeat = 1'b1;
    tick();
    heartbeat = 1'b0;
    chk("t6_hb_edge_run", 32'(state), 2);
    chk("t6_hb_edge_err", 32'(err), 0);
    repeat (3) tick();
    async_rst("t6_arst", 2);
    repeat (4) tick();
    chk("t6_reboot", 32'(state), 1);

    // narrow counter saturation
    for (int p = 0; p < 20; p++) begin
      heartbeat = 1'b1;
      tick();
      heartbeat = 1'b0;
      tick();
    end
    chk("t6_hb4_sat", 32'(hb4), 15);
    chk("t6_hb16", 32'(hb_count), 20);

    // randomised traffic
    hb_pct = 12;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) begin
        case ($urandom_range(0, 4))
          0: hb_pct = 0;
          1: hb_pct = 5;
          2: hb_pct = 12;
          3: hb_pct = 30;
          default: hb_pct = 80;
        endcase
      end
      if ($urandom_range(0, 999) < 3)
        async_rst("rnd_arst", int'($urandom_range(1, 3)));
      heartbeat = ($urandom_range(0, 99) < hb_pct);
      clr = ($urandom_range(0, 99) == 0);
      fault_in = ($urandom_range(0, 299) == 0);
      halt = ($urandom_range(0, 399) == 0);
      tick();
    end
    heartbeat = 1'b0;
    clr = 1'b0;
    fault_in = 1'b0;
    halt = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
